// File: rtl/keccak_word_packer.sv
// Keccak rate-block packer: collects 32-bit CPU words into one rate block,
// applies pad10*1 after the last word and hands blocks to the core via valid/ack.
module keccak_word_packer #(
  parameter int unsigned RATE_WORDS = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       keccak_en,
  input  logic [31:0]                keccak_data32,
  input  logic                       is_last,
  output logic                       keccak_ready,
  output logic                       err_drop,
  output logic [RATE_WORDS*32-1:0]   blk_out,
  output logic                       blk_valid,
  output logic                       blk_first,
  output logic                       blk_last,
  input  logic                       blk_ack
);

  localparam int unsigned IDX_W = $clog2(RATE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);
  localparam logic [IDX_W-1:0] PENU_IDX = IDX_W'(RATE_WORDS - 2);
  localparam logic [31:0] PAD_FIRST = 32'h0000_0001;
  localparam logic [31:0] PAD_FINAL = 32'h8000_0000;
  localparam logic [31:0] PAD_BOTH  = 32'h8000_0001;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    PADBLK = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [31:0]      words [RATE_WORDS];
  logic             first_pend;
  logic             pad_pend;

  assign idx_inc      = idx + IDX_W'(1);
  assign keccak_ready = (state == FILL);

  // Flatten the word buffer onto the block output (word k at bits 32k+31:32k).
  always_comb begin
    blk_out = '0;
    for (int k = 0; k < int'(RATE_WORDS); k++) begin
      blk_out[32*k +: 32] = words[k];
    end
  end

  // Packer FSM: word capture, padding, block handshake and drop detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      idx        <= '0;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      first_pend <= 1'b1;
      pad_pend   <= 1'b0;
      err_drop   <= 1'b0;
      for (int k = 0; k < int'(RATE_WORDS); k++) words[k] <= '0;
    end else begin
      if (keccak_en && (state != FILL)) err_drop <= 1'b1;

      case (state)
        FILL: begin
          if (keccak_en) begin
            words[idx] <= keccak_data32;
            if (is_last) begin
              // Trailing pad lands in this block unless the message filled it exactly.
              state     <= HOLD;
              blk_valid <= 1'b1;
              blk_first <= first_pend;
              if (idx == LAST_IDX) begin
                blk_last <= 1'b0;
                pad_pend <= 1'b1;
              end else if (idx == PENU_IDX) begin
                blk_last        <= 1'b1;
                words[LAST_IDX] <= PAD_BOTH;
              end else begin
                blk_last        <= 1'b1;
                words[idx_inc]  <= PAD_FIRST;
                words[LAST_IDX] <= PAD_FINAL;
              end
            end else if (idx == LAST_IDX) begin
              state     <= HOLD;
              blk_valid <= 1'b1;
              blk_first <= first_pend;
              blk_last  <= 1'b0;
            end else begin
              idx <= idx_inc;
            end
          end
        end

        HOLD: begin
          if (blk_ack) begin
            blk_valid  <= 1'b0;
            idx        <= '0;
            first_pend <= blk_last;
            state      <= pad_pend ? PADBLK : FILL;
            for (int k = 0; k < int'(RATE_WORDS); k++) words[k] <= '0;
          end
        end

        PADBLK: begin
          // Pad-only block after a message that ended on a block boundary.
          words[0]        <= PAD_FIRST;
          words[LAST_IDX] <= PAD_FINAL;
          pad_pend        <= 1'b0;
          blk_first       <= 1'b0;
          blk_last        <= 1'b1;
          blk_valid       <= 1'b1;
          state           <= HOLD;
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
